ccu_arith: RTL and testbench
============================

# ccu_arith

Parametrised arithmetic-order control unit for the EDSAC control section. Accepts the MCU stimulating pulse for A, S and C orders, aligns to the minor-cycle timing, and produces per-order operand gating windows for one minor cycle (short) or two minor cycles (long). It issues the end pulse back to the sequencing logic and flags protocol and timing faults. It sits between the MCU handshake and the arithmetic/multiplicand tank gating.

## Interface
Parameters:
- MINOR_CYCLE_LEN, 18, clocks between successive d0 pulses; sets the watchdog limit.
- MAX_MINOR, 2, maximum operand length in minor cycles; sets the counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- d0  in  1  minor-cycle start pulse; one clk wide.
- odd  in  1  high throughout odd minor cycles; valid when d0 is high.
- r2  in  1  MCU stimulating pulse (load complete); one clk wide.
- inhibit  in  1  g8-equivalent; when high, r2 is ignored.
- order  in  2  order code, sampled with r2: 00 = A, 01 = S, 10 = C, 11 = none.
- long_op  in  1  sampled with r2; 1 = two-minor-cycle operand.
- busy  out  1  high from acceptance until ep.
- gate  out  1  OR of the three order gates.
- add_gate  out  1  A-order operand window.
- sub_gate  out  1  S-order operand window.
- col_gate  out  1  C-order operand window.
- ep  out  1  end pulse; one clk wide.
- err  out  1  sticky fault flag; cleared only by rst.

## Operation
- States: IDLE, ARMED, GATE.
- IDLE → ARMED:
  - Requires r2 & ~inhibit & order != 11 on a clock edge.
  - order and long_op are latched; busy rises the next cycle.
  - order 11 with r2 is ignored: no state change, no err.
- ARMED → GATE:
  - Short operands move on the first sampled d0 & odd.
  - Long operands move on the first sampled d0 & ~odd, so the even/odd pair aligns.
  - A d0 in the same cycle as the accepting r2 is not used for alignment.
- GATE:
  - Exactly one of add_gate, sub_gate or col_gate is high, chosen by the latched order; gate follows it.
  - A minor counter (width clog2(MAX_MINOR+1)) counts d0 pulses sampled in GATE.
  - On the d0 that completes the required count (1 short, 2 long), the block asserts ep for one cycle, drops all gates and busy, and returns to IDLE.
- r2 accepted-condition while busy:
  - The request is ignored and err is set.
  - The operation in progress continues unaffected.
- Watchdog:
  - In ARMED or GATE, a counter counts clocks since the last d0 (or since entry).
  - If it reaches MINOR_CYCLE_LEN+1, err is set, all gates drop, no ep is issued, and the state returns to IDLE.
- long_op = 1 with MAX_MINOR < 2: treated as a short operand and err is set at acceptance.
- rst asserted at any time: state goes to IDLE, counters clear, and all outputs go to 0 asynchronously.

## Timing
- Reset value of every output: 0.
- Let T be the edge at which the aligning d0 is sampled. Then gate and the order gate are high from T+1 through T+L (short) or T+2L (long), where L = MINOR_CYCLE_LEN.
- ep is high only at cycle T+L+1 (short) or T+2L+1 (long), which is the same cycle the gates fall.
- busy rises one cycle after r2 is accepted and falls together with ep.
- A new r2 is accepted in the ep cycle, since the state is IDLE at that edge.
- All outputs are registered, so there is no combinational path from inputs to outputs.

## Structure
- Shared package edsac_ctrl_pkg holds:
  - the order enum: ORD_A, ORD_S, ORD_C, ORD_NONE;
  - the state enum: CCU_IDLE, CCU_ARMED, CCU_GATE;
  - the default MINOR_CYCLE_LEN constant, 18.
- One sub-module, minor_cycle_watchdog:
  - clock counter with parameter LIMIT;
  - inputs enable and d0;
  - output timeout.

## Test plan
All cases use MINOR_CYCLE_LEN = 18, with d0 every 18 clocks and odd alternating.
- Short A order: r2 with order=00, long_op=0, followed by odd d0 at T → add_gate high for T+1..T+18, ep only at T+19, sub_gate and col_gate stay 0.
- Long S order: r2 with order=01, long_op=1, followed by an even d0 at T, while the odd d0 at T−18 is ignored → sub_gate high for 36 cycles, ep at T+37.
- Inhibit and no-op: r2 with inhibit=1, then r2 with order=11 → busy, gate, ep and err all remain 0.
- Overlap: a second r2 (C order) at T+5 during a short A gate → A completes normally with ep at T+19, col_gate never rises, err=1 until rst.
- Watchdog: after acceptance, suppress d0 for 19 clocks → err=1, gates 0, no ep, busy=0; a following valid r2 with d0 resumed is processed normally.
- Reset mid-gate: assert rst at T+10 of a long C op → all outputs 0 within the same cycle (asynchronous); after release, no ep appears and a new A order completes normally.

Source files
------------

// File: rtl/edsac_ctrl_pkg.sv
// Shared EDSAC control-section types and constants.
//   order_e     : order code carried with the MCU stimulating pulse (A, S, C, none).
//   ccu_state_e : arithmetic-order control unit sequencing states.
//   DEFAULT_MINOR_CYCLE_LEN : clocks between successive d0 pulses.
package edsac_ctrl_pkg;

    localparam int unsigned DEFAULT_MINOR_CYCLE_LEN = 18;

    typedef enum logic [1:0] {
        ORD_A    = 2'b00,
        ORD_S    = 2'b01,
        ORD_C    = 2'b10,
        ORD_NONE = 2'b11
    } order_e;

    typedef enum logic [1:0] {
        CCU_IDLE  = 2'b00,
        CCU_ARMED = 2'b01,
        CCU_GATE  = 2'b10
    } ccu_state_e;

endpackage

// File: rtl/ccu_arith_if.sv
// Handshake and gating bundle between the MCU, the arithmetic-order control unit
// and the tank gating logic.
//   master : MCU/timing side; drives d0, odd, r2, inhibit, order, long_op.
//   slave  : control unit side; drives busy, gate, add_gate, sub_gate, col_gate, ep, err.
interface ccu_arith_if;
    import edsac_ctrl_pkg::*;

    logic   d0;
    logic   odd;
    logic   r2;
    logic   inhibit;
    order_e order;
    logic   long_op;
    logic   busy;
    logic   gate;
    logic   add_gate;
    logic   sub_gate;
    logic   col_gate;
    logic   ep;
    logic   err;

    modport master (
        output d0, odd, r2, inhibit, order, long_op,
        input  busy, gate, add_gate, sub_gate, col_gate, ep, err
    );

    modport slave (
        input  d0, odd, r2, inhibit, order, long_op,
        output busy, gate, add_gate, sub_gate, col_gate, ep, err
    );

endinterface

// File: rtl/minor_cycle_watchdog.sv
// Counts clocks since the last d0 (or since enable rose) and flags a missing
// minor-cycle pulse.
//   clk, rst : clock and asynchronous active-high reset.
//   enable   : count only while high; counter held at zero otherwise.
//   d0       : minor-cycle start pulse; restarts the count.
//   timeout  : high on the clock edge at which the count would reach LIMIT.
module minor_cycle_watchdog #(
    parameter int unsigned LIMIT = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic d0,
    output logic timeout
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || d0) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires one edge early so the consumer acts on the very edge the limit is hit.
    assign timeout = enable & ~d0 & (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ccu_arith.sv
// Arithmetic-order control unit: accepts the MCU stimulating pulse for A, S and C
// orders, aligns to minor-cycle timing and opens a one- or two-minor-cycle operand
// window on the gate of the latched order, then returns an end pulse.
//   clk, rst : clock and asynchronous active-high reset.
//   bus      : ccu_arith_if slave; inputs d0, odd, r2, inhibit, order, long_op;
//              registered outputs busy, gate, add_gate, sub_gate, col_gate, ep, err.
module ccu_arith
    import edsac_ctrl_pkg::*;
#(
    parameter int unsigned MINOR_CYCLE_LEN = DEFAULT_MINOR_CYCLE_LEN,
    parameter int unsigned MAX_MINOR       = 2
) (
    input  logic       clk,
    input  logic       rst,
    ccu_arith_if.slave bus
);

    localparam int unsigned MINOR_W = $clog2(MAX_MINOR + 1);
    localparam bit          LONG_OK = (MAX_MINOR >= 2);

    ccu_state_e       state_q, state_d;
    order_e           ord_q, ord_d;
    logic             long_q, long_d;
    logic [MINOR_W-1:0] minor_q, minor_d;
    logic             busy_q, busy_d;
    logic             add_q, add_d;
    logic             sub_q, sub_d;
    logic             col_q, col_d;
    logic             gate_q, gate_d;
    logic             ep_q, ep_d;
    logic             err_q, err_d;

    logic             accept_req;
    logic             align_d0;
    logic             timeout;
    logic [MINOR_W-1:0] minor_inc;
    logic [MINOR_W-1:0] minor_need;

    assign accept_req = bus.r2 & ~bus.inhibit & (bus.order != ORD_NONE);
    // Long operands start on an even minor cycle so the even/odd pair lines up.
    assign align_d0   = bus.d0 & (long_q ? ~bus.odd : bus.odd);
    assign minor_inc  = minor_q + 1'b1;
    assign minor_need = long_q ? MINOR_W'(2) : MINOR_W'(1);

    minor_cycle_watchdog #(
        .LIMIT (MINOR_CYCLE_LEN + 1)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .enable  (state_q != CCU_IDLE),
        .d0      (bus.d0),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state_q;
        ord_d   = ord_q;
        long_d  = long_q;
        minor_d = minor_q;
        busy_d  = busy_q;
        add_d   = add_q;
        sub_d   = sub_q;
        col_d   = col_q;
        ep_d    = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            CCU_IDLE: begin
                minor_d = '0;
                if (accept_req) begin
                    state_d = CCU_ARMED;
                    ord_d   = bus.order;
                    long_d  = bus.long_op & LONG_OK;
                    busy_d  = 1'b1;
                    if (bus.long_op && !LONG_OK) begin
                        err_d = 1'b1;
                    end
                end
            end

            CCU_ARMED: begin
                if (accept_req) begin
                    err_d = 1'b1;
                end
                if (timeout) begin
                    state_d = CCU_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (align_d0) begin
                    state_d = CCU_GATE;
                    minor_d = '0;
                    unique case (ord_q)
                        ORD_A:   add_d = 1'b1;
                        ORD_S:   sub_d = 1'b1;
                        ORD_C:   col_d = 1'b1;
                        default: ;
                    endcase
                end
            end

            CCU_GATE: begin
                if (accept_req) begin
                    err_d = 1'b1;
                end
                if (timeout) begin
                    state_d = CCU_IDLE;
                    busy_d  = 1'b0;
                    add_d   = 1'b0;
                    sub_d   = 1'b0;
                    col_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (bus.d0) begin
                    if (minor_inc == minor_need) begin
                        state_d = CCU_IDLE;
                        minor_d = '0;
                        busy_d  = 1'b0;
                        add_d   = 1'b0;
                        sub_d   = 1'b0;
                        col_d   = 1'b0;
                        ep_d    = 1'b1;
                    end else begin
                        minor_d = minor_inc;
                    end
                end
            end

            default: begin
                state_d = CCU_IDLE;
                busy_d  = 1'b0;
                add_d   = 1'b0;
                sub_d   = 1'b0;
                col_d   = 1'b0;
            end
        endcase

        gate_d = add_d | sub_d | col_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CCU_IDLE;
            ord_q   <= ORD_NONE;
            long_q  <= 1'b0;
            minor_q <= '0;
            busy_q  <= 1'b0;
            add_q   <= 1'b0;
            sub_q   <= 1'b0;
            col_q   <= 1'b0;
            gate_q  <= 1'b0;
            ep_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ord_q   <= ord_d;
            long_q  <= long_d;
            minor_q <= minor_d;
            busy_q  <= busy_d;
            add_q   <= add_d;
            sub_q   <= sub_d;
            col_q   <= col_d;
            gate_q  <= gate_d;
            ep_q    <= ep_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.gate     = gate_q;
    assign bus.add_gate = add_q;
    assign bus.sub_gate = sub_q;
    assign bus.col_gate = col_q;
    assign bus.ep       = ep_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_ccu_arith.sv
// Self-checking bench for ccu_arith. d0 falls on every edge whose index is a
// multiple of L; odd is high for odd minor-cycle numbers. Expected outputs are
// derived from edge arithmetic: the accepting edge a, the aligning d0 edge t and
// the completing edge fin = t + n*L.
module tb_ccu_arith;
    import edsac_ctrl_pkg::*;

    localparam int L = 18;

    logic clk = 1'b0;
    logic rst;

    ccu_arith_if bus ();

    ccu_arith #(
        .MINOR_CYCLE_LEN (L),
        .MAX_MINOR       (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc;
    int n_cmp;
    int n_bad;
    bit supp;
    bit err_exp;

    initial begin
        #1000000;
        $display("FAIL global_time_limit reached at cyc=%0d (required: finish earlier)", cyc);
        $fatal(1);
    end

    // d0/odd for the upcoming edge cyc+1
    task automatic drive_timing();
        int e;
        e = cyc + 1;
        bus.d0  = ((e % L) == 0) && !supp;
        bus.odd = ((e / L) % 2) == 1;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        drive_timing();
    endtask

    function automatic logic [6:0] obs();
        return {bus.busy, bus.gate, bus.add_gate, bus.sub_gate, bus.col_gate, bus.ep, bus.err};
    endfunction

    // {busy, gate, add, sub, col, ep, err} seen after edge e
    function automatic logic [6:0] model(int e, int a, int t, int fin, int ord, bit ev);
        logic g;
        g = (e >= t) && (e < fin);
        return {(e >= a) && (e < fin), g, g && (ord == 0), g && (ord == 1), g && (ord == 2),
                e == fin, ev};
    endfunction

    function automatic int align_edge(int a, bit lng);
        int e;
        e = (a / L + 1) * L;
        if ((((e / L) % 2) == 1) == lng) e += L;
        return e;
    endfunction

    task automatic send_r2(input int ord, input bit lng, input bit inh);
        bus.r2      = 1'b1;
        bus.order   = order_e'(ord[1:0]);
        bus.long_op = lng;
        bus.inhibit = inh;
        step();
        bus.r2      = 1'b0;
        bus.inhibit = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        err_exp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_async got=%b exp=%b", obs(), 7'b0);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 2) rst = 1'b0;
            n_cmp++;
            if (obs() !== 7'b0) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs(), 7'b0);
            end
        end
        err_exp = 1'b0;
    endtask

    task automatic test_short_a();
        int a, t, fin;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                // r2 coincident with an odd d0: that d0 must not align
                while (!(((cyc + 1) % L) == 0 && (((cyc + 1) / L) % 2) == 1)) step();
            end else begin
                repeat ($urandom_range(1, 30)) step();
            end
            a = cyc + 1;
            t = align_edge(a, 1'b0);
            fin = t + L;
            send_r2(0, 1'b0, 1'b0);
            while (cyc <= fin + 1) begin
                n_cmp++;
                if (obs() !== model(cyc, a, t, fin, 0, err_exp)) begin
                    n_bad++;
                    $display("FAIL short_a cyc=%0d got=%b exp=%b", cyc, obs(),
                             model(cyc, a, t, fin, 0, err_exp));
                end
                step();
            end
        end
    endtask

    task automatic test_long_s();
        int a, t, fin;
        // place r2 so the next d0 is odd and must be skipped
        while (!((((cyc + 1) % L) != 0) && ((((cyc + 1) / L) + 1) % 2) == 1)) step();
        a = cyc + 1;
        t = align_edge(a, 1'b1);
        fin = t + 2 * L;
        send_r2(1, 1'b1, 1'b0);
        while (cyc <= fin + 1) begin
            n_cmp++;
            if (obs() !== model(cyc, a, t, fin, 1, err_exp)) begin
                n_bad++;
                $display("FAIL long_s cyc=%0d got=%b exp=%b", cyc, obs(),
                         model(cyc, a, t, fin, 1, err_exp));
            end
            step();
        end
    endtask

    task automatic test_inhibit_noop();
        send_r2(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1);
        repeat (3) step();
        send_r2(3, 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 2 * L + 4; i++) begin
            n_cmp++;
            if (obs() !== {6'b0, err_exp}) begin
                n_bad++;
                $display("FAIL inhibit_noop cyc=%0d got=%b exp=%b", cyc, obs(), {6'b0, err_exp});
            end
            step();
        end
    endtask

    task automatic test_random_ops();
        int a, t, fin, ord;
        bit lng;
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 40)) step();
            ord = int'($urandom_range(0, 2));
            lng = 1'($urandom_range(0, 1));
            a = cyc + 1;
            t = align_edge(a, lng);
            fin = t + (lng ? 2 : 1) * L;
            send_r2(ord, lng, 1'b0);
            while (cyc <= fin + 1) begin
                n_cmp++;
                if (obs() !== model(cyc, a, t, fin, ord, err_exp)) begin
                    n_bad++;
                    $display("FAIL random_op k=%0d ord=%0d long=%0d cyc=%0d got=%b exp=%b", k, ord,
                             lng, cyc, obs(), model(cyc, a, t, fin, ord, err_exp));
                end
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        int a, t, fin, ord;
        bit lng;
        ord = int'($urandom_range(0, 2));
        lng = 1'($urandom_range(0, 1));
        a = cyc + 1;
        t = align_edge(a, lng);
        fin = t + (lng ? 2 : 1) * L;
        send_r2(ord, lng, 1'b0);
        for (int k = 0; k < 3; k++) begin
            while (cyc <= fin) begin
                n_cmp++;
                if (obs() !== model(cyc, a, t, fin, ord, err_exp)) begin
                    n_bad++;
                    $display("FAIL back_to_back k=%0d cyc=%0d got=%b exp=%b", k, cyc, obs(),
                             model(cyc, a, t, fin, ord, err_exp));
                end
                if (cyc == fin) break;
                step();
            end
            // new r2 sampled on the edge after ep rises
            ord = int'($urandom_range(0, 2));
            lng = 1'($urandom_range(0, 1));
            a = cyc + 1;
            t = align_edge(a, lng);
            fin = t + (lng ? 2 : 1) * L;
            send_r2(ord, lng, 1'b0);
        end
        while (cyc <= fin + 1) begin
            n_cmp++;
            if (obs() !== model(cyc, a, t, fin, ord, err_exp)) begin
                n_bad++;
                $display("FAIL back_to_back_last cyc=%0d got=%b exp=%b", cyc, obs(),
                         model(cyc, a, t, fin, ord, err_exp));
            end
            step();
        end
    endtask

    task automatic test_overlap();
        int a, t, fin;
        logic [6:0] exp_v;
        repeat ($urandom_range(0, 20)) step();
        a = cyc + 1;
        t = align_edge(a, 1'b0);
        fin = t + L;
        send_r2(0, 1'b0, 1'b0);
        while (cyc <= fin + 1) begin
            exp_v = model(cyc, a, t, fin, 0, (cyc >= t + 5) ? 1'b1 : err_exp);
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL overlap cyc=%0d got=%b exp=%b", cyc, obs(), exp_v);
            end
            bus.r2    = (cyc == t + 4);
            bus.order = ORD_C;
            step();
        end
        err_exp = 1'b1;
        repeat (5) step();
        n_cmp++;
        if (obs() !== 7'b0000001) begin
            n_bad++;
            $display("FAIL overlap_sticky got=%b exp=%b", obs(), 7'b0000001);
        end
    endtask

    task automatic test_watchdog();
        int a, t, fin, ord;
        logic [6:0] exp_v;
        logic g;
        do_reset();
        // timeout while armed
        repeat ($urandom_range(0, 20)) step();
        ord = int'($urandom_range(0, 2));
        supp = 1'b1;
        drive_timing();
        a = cyc + 1;
        send_r2(ord, 1'b0, 1'b0);
        while (cyc <= a + 21) begin
            exp_v = {cyc < a + 19, 5'b0, cyc >= a + 19};
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL watchdog_armed cyc=%0d got=%b exp=%b", cyc, obs(), exp_v);
            end
            if (cyc == a + 19) begin
                supp = 1'b0;
                drive_timing();
            end
            step();
        end
        err_exp = 1'b1;
        // normal operation afterwards
        ord = int'($urandom_range(0, 2));
        a = cyc + 1;
        t = align_edge(a, 1'b0);
        fin = t + L;
        send_r2(ord, 1'b0, 1'b0);
        while (cyc <= fin + 1) begin
            n_cmp++;
            if (obs() !== model(cyc, a, t, fin, ord, err_exp)) begin
                n_bad++;
                $display("FAIL watchdog_resume cyc=%0d got=%b exp=%b", cyc, obs(),
                         model(cyc, a, t, fin, ord, err_exp));
            end
            step();
        end
        // timeout while gating: d0 that would end the window is suppressed
        do_reset();
        ord = int'($urandom_range(0, 2));
        a = cyc + 1;
        t = align_edge(a, 1'b0);
        send_r2(ord, 1'b0, 1'b0);
        while (cyc <= t + 21) begin
            g = (cyc >= t) && (cyc < t + 19);
            exp_v = {cyc < t + 19, g, g && ord == 0, g && ord == 1, g && ord == 2, 1'b0,
                     cyc >= t + 19};
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL watchdog_gate cyc=%0d got=%b exp=%b", cyc, obs(), exp_v);
            end
            if (cyc == t + 17) begin
                supp = 1'b1;
                drive_timing();
            end
            if (cyc == t + 19) begin
                supp = 1'b0;
                drive_timing();
            end
            step();
        end
        err_exp = 1'b1;
    endtask

    task automatic test_reset_mid_gate();
        int a, t, fin;
        a = cyc + 1;
        t = align_edge(a, 1'b1);
        fin = t + 2 * L;
        send_r2(2, 1'b1, 1'b0);
        while (cyc <= t + 10) begin
            n_cmp++;
            if (obs() !== model(cyc, a, t, fin, 2, err_exp)) begin
                n_bad++;
                $display("FAIL mid_gate_pre cyc=%0d got=%b exp=%b", cyc, obs(),
                         model(cyc, a, t, fin, 2, err_exp));
            end
            if (cyc == t + 10) break;
            step();
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 7'b0) begin
            n_bad++;
            $display("FAIL mid_gate_async got=%b exp=%b", obs(), 7'b0);
        end
        step();
        step();
        rst = 1'b0;
        err_exp = 1'b0;
        while (cyc <= fin + 3) begin
            n_cmp++;
            if (obs() !== 7'b0) begin
                n_bad++;
                $display("FAIL mid_gate_quiet cyc=%0d got=%b exp=%b", cyc, obs(), 7'b0);
            end
            step();
        end
        a = cyc + 1;
        t = align_edge(a, 1'b0);
        fin = t + L;
        send_r2(0, 1'b0, 1'b0);
        while (cyc <= fin + 1) begin
            n_cmp++;
            if (obs() !== model(cyc, a, t, fin, 0, err_exp)) begin
                n_bad++;
                $display("FAIL mid_gate_after cyc=%0d got=%b exp=%b", cyc, obs(),
                         model(cyc, a, t, fin, 0, err_exp));
            end
            step();
        end
    endtask

    initial begin
        cyc         = 0;
        n_cmp       = 0;
        n_bad       = 0;
        supp        = 1'b0;
        err_exp     = 1'b0;
        bus.r2      = 1'b0;
        bus.inhibit = 1'b0;
        bus.order   = ORD_NONE;
        bus.long_op = 1'b0;
        drive_timing();

        test_reset();
        test_short_a();
        test_long_s();
        test_inhibit_noop();
        test_random_ops();
        test_back_to_back();
        test_overlap();
        test_watchdog();
        test_reset_mid_gate();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
